// File: rtl/sram_ctrl.sv
// sram_ctrl: 16x8 register-file SRAM with a req/ack command handshake.
// Define SRAM_CLEAR_EN to zero the whole array in a 16-cycle sweep after every reset.
module sram_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       ack,
  output logic       busy
);
`ifdef SRAM_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, CLEAR} state_t;
  localparam state_t RST_ST = CLEAR;
  logic [3:0] ptr_q, ptr_d;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  localparam state_t RST_ST = IDLE;
`endif
  state_t     state_q, state_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic [7:0] q_q, q_d;
  logic [7:0] mem [16];
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    q_d       = q_q;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = din_q;
`ifdef SRAM_CLEAR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        state_d = we ? WRITE : READ;
        we_d    = we;
        addr_d  = addr;
        din_d   = din;
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_d = DONE;
      end
      READ: begin
        q_d     = mem[addr_q];
        state_d = DONE;
      end
      DONE: state_d = IDLE;
`ifdef SRAM_CLEAR_EN
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = 8'h00;
        ptr_d     = ptr_q + 4'd1;
        state_d   = &ptr_q ? IDLE : CLEAR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ST;
      we_q    <= 1'b0;
      addr_q  <= 4'h0;
      din_q   <= 8'h00;
      q_q     <= 8'h00;
`ifdef SRAM_CLEAR_EN
      ptr_q   <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      q_q     <= q_d;
`ifdef SRAM_CLEAR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
  // Array has no reset so contents survive a reset; aborted writes never reach here because state is forced out of WRITE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign q    = q_q;
  assign ack  = state_q == DONE;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed scoreboard bench for sram_ctrl; follows SRAM_CLEAR_EN when defined.
module tb_sram_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] din = 8'h00;
  logic [7:0] q;
  logic       ack, busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] last_q = 8'h00;
  logic [5:0] ack_pat;
  int         busy_cnt;

  sram_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .din(din), .q(q), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete command: issue, scramble inputs after capture, check latency, ack pulse and q.
  task automatic cmd(input logic w, input logic [3:0] a, input logic [7:0] d, input logic poke);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; din = d;
    if (w) model[a] = d;
    else exp_q.push_back(model[a]);
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ~a; din = ~d;
    @(negedge clk);
    chk("busy_cmd", {7'h0, busy}, 8'h01);
    chk("ack_early", {7'h0, ack}, 8'h00);
    @(posedge clk); #1;
    if (poke) begin req = 1'b1; we = 1'b0; end
    @(negedge clk);
    chk("ack_pulse", {7'h0, ack}, 8'h01);
    if (!w) last_q = exp_q.pop_front();
    chk(w ? "q_hold" : "q_read", q, last_q);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("ack_drop", {7'h0, ack}, 8'h00);
    chk("busy_idle", {7'h0, busy}, 8'h00);
    if (poke) begin
      @(negedge clk);
      chk("poke_ignored_ack", {7'h0, ack}, 8'h00);
      chk("poke_ignored_busy", {7'h0, busy}, 8'h00);
    end
  endtask

  initial begin
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_ack", {7'h0, ack}, 8'h00);
`ifdef SRAM_CLEAR_EN
    chk("rst_busy", {7'h0, busy}, 8'h01);
`else
    chk("rst_busy", {7'h0, busy}, 8'h00);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef SRAM_CLEAR_EN
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 2) begin req = 1'b1; we = 1'b1; addr = 4'h4; din = 8'hEE; end
      if (i == 5) req = 1'b0;
    end
    chk("clear_busy_cycles", 8'(busy_cnt), 8'd16);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) cmd(1'b0, 4'(i), 8'h00, 1'b0);
`endif
    cmd(1'b1, 4'h3, 8'hA5, 1'b0);
    cmd(1'b0, 4'h3, 8'h00, 1'b0);
    cmd(1'b1, 4'h0, 8'h11, 1'b0);
    cmd(1'b1, 4'hF, 8'h22, 1'b0);
    cmd(1'b0, 4'hF, 8'h00, 1'b0);
    cmd(1'b0, 4'h0, 8'h00, 1'b0);
    cmd(1'b1, 4'h7, 8'h33, 1'b1);
    cmd(1'b0, 4'h7, 8'h00, 1'b0);
    cmd(1'b1, 4'h5, 8'h5C, 1'b0);
    cmd(1'b0, 4'h5, 8'h00, 1'b0);
    cmd(1'b1, 4'h5, 8'hFF, 1'b0);
    cmd(1'b0, 4'h5, 8'h00, 1'b0);
    // req held high: write then read back-to-back, 3 cycles each.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 4'h9; din = 8'h9A;
    model[9] = 8'h9A;
    exp_q.push_back(8'h9A);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin we = 1'b0; din = 8'h00; end
      if (i == 4) req = 1'b0;
      @(negedge clk);
      ack_pat[i] = ack;
      if (i == 4) last_q = exp_q.pop_front();
    end
    chk("b2b_ack_pattern", {2'b00, ack_pat}, 8'b0001_0010);
    chk("b2b_q", q, last_q);
    // Reset in the middle of a WRITE cycle aborts the write.
    cmd(1'b1, 4'h2, 8'h10, 1'b0);
    cmd(1'b0, 4'h2, 8'h00, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 4'h2; din = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", q, 8'h00);
    chk("midrst_ack", {7'h0, ack}, 8'h00);
`ifdef SRAM_CLEAR_EN
    chk("midrst_busy", {7'h0, busy}, 8'h01);
`else
    chk("midrst_busy", {7'h0, busy}, 8'h00);
`endif
    @(posedge clk); #1 rst = 1'b0;
    last_q = 8'h00;
`ifdef SRAM_CLEAR_EN
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (17) @(posedge clk);
`endif
    @(negedge clk);
    chk("post_rst_q", q, 8'h00);
    cmd(1'b1, 4'h8, 8'h44, 1'b0);
    cmd(1'b0, 4'h2, 8'h00, 1'b0);
    cmd(1'b0, 4'h8, 8'h00, 1'b0);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
